pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. It watches the ID, EX, MEM and WB stages and drives the hold and flush enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers load-use interlocks, taken-branch squashes and multi-cycle data-memory waits with a timeout-to-halt. It also keeps saturating stall and retire counters for performance readout.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive memory-stall cycles before HALT; legal range is 2 or more.
- WAIT_W, 8: width of the internal wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.
- CNT_W, 32: width of the stall and retire counters.

Ports:
- clk_cpu, in, 1: CPU clock; all state updates on the rising edge.
- rst_cpu_n, in, 1: reset, synchronous, active-low.
- rs1_id / rs2_id, in, 5 each: source registers of the instruction in ID.
- rs1_re_id / rs2_re_id, in, 1 each: the ID instruction actually reads rs1 / rs2.
- rd_ex, in, 5: destination register of the instruction in EX.
- rd_we_ex, in, 1: the EX instruction writes rd.
- wd_sel_ex, in, 2: writeback source of the EX instruction; the value `dram marks a load.
- branch_taken_ex, in, 1: a branch or jump resolved taken in EX.
- mem_req, in, 1: the MEM stage holds a load or store.
- mem_ready, in, 1: data memory completes the access this cycle.
- halt_req, in, 1: halt request (ebreak or debug).
- have_inst_wb, in, 1: one instruction retired this cycle.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, out, 1 each: hold the corresponding register.
- flush_if_id, flush_id_ex, out, 1 each: load a bubble into the corresponding register.
- bubble_mem_wb, out, 1: drives flag_mem of MEM/WB, which suppresses retirement.
- state, out, 2: FSM state; RUN=0, MEM_WAIT=1, HALT=2.
- mem_err, out, 1: sticky flag set by a memory timeout.
- stall_cnt, out, CNT_W: count of stall cycles.
- retire_cnt, out, CNT_W: count of retired instructions.

## Operation
Derived terms:
- load_use = rd_we_ex & (wd_sel_ex==`dram) & (rd_ex!=0) & ((rs1_re_id & rs1_id==rd_ex) | (rs2_re_id & rs2_id==rd_ex)).
- mem_stall = (state!=HALT) & mem_req & ~mem_ready.

Combinational outputs, evaluated in priority order:
1. rst_cpu_n=0: all stalls 0; flush_if_id=1, flush_id_ex=1, bubble_mem_wb=1.
2. HALT: all four stalls 1, bubble_mem_wb=1, flushes 0.
3. mem_stall: all four stalls 1, bubble_mem_wb=1, flushes 0. Branch and load-use are deferred because EX is frozen.
4. branch_taken_ex: flush_if_id=1, flush_id_ex=1, everything else 0. The branch overrides load-use because the ID instruction is wrong-path.
5. load_use: stall_pc=1, stall_if_id=1, flush_id_ex=1, everything else 0. This inserts exactly one bubble.
6. Otherwise every output is 0.

FSM, next-state rules in priority order:
- Reset → RUN, with wait_cnt=0 and mem_err=0.
- Any non-HALT state with halt_req=1 → HALT.
- RUN with mem_stall → MEM_WAIT, with wait_cnt=1.
- MEM_WAIT with mem_stall and wait_cnt==MEM_TIMEOUT-1 → HALT, with mem_err←1.
- MEM_WAIT with mem_stall otherwise → stays in MEM_WAIT, wait_cnt+1.
- MEM_WAIT without mem_stall, because mem_ready arrived or mem_req dropped → RUN, with wait_cnt=0.
- HALT is left only through reset.

Counters:
- stall_cnt increments in each cycle with stall_pc=1 while state!=HALT.
- retire_cnt increments on have_inst_wb=1.
- Both saturate at all-ones and both clear on reset.

## Timing
- Reset values: state=0, mem_err=0, stall_cnt=0, retire_cnt=0, internal wait_cnt=0. Combinational outputs during reset follow rule 1.
- Reset asserted mid-MEM_WAIT or in HALT returns the block to RUN on the same edge and discards wait progress.
- Stall and flush outputs are zero-latency combinational, so the pipeline registers act on the same edge.
- A load-use hazard costs 1 cycle and a taken branch costs 2 bubbles.
- A memory access ready in its first MEM cycle costs 0 stall cycles.
- An access ready after N stall cycles, with N < MEM_TIMEOUT, costs N cycles, and state returns to RUN on the edge that samples mem_ready.
- After MEM_TIMEOUT consecutive stall cycles the next state is HALT and mem_err rises on that same edge.
- halt_req arriving together with mem_ready or a branch: this cycle's outputs follow the priority list, and the next state is HALT.
- Counters update one edge after the qualifying cycle.

## Test plan
- EX holds a load with rd_ex=5 and ID reads rs1=5: stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle, state stays 0, stall_cnt→1. Repeat with rd_ex=0: no stall.
- Load-use and branch_taken_ex=1 in the same cycle: only flush_if_id=flush_id_ex=1, stall_cnt unchanged.
- mem_req=1 with mem_ready held low for 3 cycles: all stalls and bubble_mem_wb=1 for 3 cycles, state sequence 0,1,1,1 then 0, stall_cnt=3.
- With MEM_TIMEOUT=4, mem_ready never rises: after 4 stall cycles state=2 and mem_err=1, stalls stay 1; pulsing rst_cpu_n low clears both to 0.
- halt_req pulsed for 1 cycle in RUN: state=2 permanently, mem_err=0, stall_cnt frozen.
- 10 pulses of have_inst_wb: retire_cnt=10. With CNT_W=4 and 20 pulses: retire_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of pipeline-facing signals between the five-stage datapath and the
// hazard controller.
//   master : pipeline side. Drives the stage observations and reads back the
//            hold/flush enables, FSM state, error flag and counters.
//   slave  : hazard controller side (the mirror of master).
// Parameter CNT_W sets the width of the stall and retire counters and must
// match the CNT_W of the controller it is connected to.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // ID stage
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             rs1_re_id;
    logic             rs2_re_id;
    // EX stage
    logic [4:0]       rd_ex;
    logic             rd_we_ex;
    logic [1:0]       wd_sel_ex;
    logic             branch_taken_ex;
    // MEM stage / data memory handshake
    logic             mem_req;
    logic             mem_ready;
    // Misc
    logic             halt_req;
    logic             have_inst_wb;
    // Pipeline register controls
    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             stall_ex_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             bubble_mem_wb;
    // Status and performance readout
    logic [1:0]       state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output rs1_id, rs2_id, rs1_re_id, rs2_re_id,
        output rd_ex, rd_we_ex, wd_sel_ex, branch_taken_ex,
        output mem_req, mem_ready, halt_req, have_inst_wb,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        input  flush_if_id, flush_id_ex, bubble_mem_wb,
        input  state, mem_err, stall_cnt, retire_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_re_id, rs2_re_id,
        input  rd_ex, rd_we_ex, wd_sel_ex, branch_taken_ex,
        input  mem_req, mem_ready, halt_req, have_inst_wb,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        output flush_if_id, flush_id_ex, bubble_mem_wb,
        output state, mem_err, stall_cnt, retire_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the five-stage RISC-V pipeline. Handles
// load-use interlocks, taken-branch squashes and multi-cycle data-memory
// waits with a timeout that halts the core, and keeps saturating stall and
// retire counters.
// Ports:
//   clk_cpu   : CPU clock, all state changes on the rising edge
//   rst_cpu_n : synchronous active-low reset
//   hz        : pipe_hazard_ctrl_if.slave - stage observations in, hold/flush
//               enables, FSM state (RUN=0, MEM_WAIT=1, HALT=2), sticky
//               mem_err and the stall/retire counters out
// Parameters:
//   MEM_TIMEOUT : consecutive memory-stall cycles before HALT (>= 2)
//   WAIT_W      : wait counter width, 2**WAIT_W > MEM_TIMEOUT
//   CNT_W       : stall/retire counter width
// ---------------------------------------------------------------------------
`ifndef DRAM
`define DRAM 2'd1
`endif

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int WAIT_W      = 8,
    parameter int CNT_W       = 32
) (
    input  logic                 clk_cpu,
    input  logic                 rst_cpu_n,
    pipe_hazard_ctrl_if.slave    hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               mem_err_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   retire_cnt_q;

    logic load_use;
    logic mem_stall;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, bubble_mem_wb;

    // x0 never carries a real dependency, so a load into x0 is ignored.
    assign load_use = hz.rd_we_ex && (hz.wd_sel_ex == `DRAM) && (hz.rd_ex != 5'd0) &&
                      ((hz.rs1_re_id && (hz.rs1_id == hz.rd_ex)) ||
                       (hz.rs2_re_id && (hz.rs2_id == hz.rd_ex)));

    assign mem_stall = (state_q != HALT) && hz.mem_req && !hz.mem_ready;

    // Zero-latency control outputs so the pipeline registers act on the same
    // edge. A memory stall freezes EX, so any branch or load-use in EX waits
    // until the access completes; a taken branch beats load-use because the
    // ID instruction is on the wrong path anyway.
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_mem_wb = 1'b0;
        if (!rst_cpu_n) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (state_q == HALT || mem_stall) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            stall_ex_mem  = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (hz.branch_taken_ex) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
        end else if (load_use) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
        end
    end

    // FSM plus counters. wait_cnt holds the number of stall cycles already
    // spent in the current access, so the timeout fires on the edge closing
    // the MEM_TIMEOUT-th stall cycle. HALT is left only through reset.
    always_ff @(posedge clk_cpu) begin
        if (!rst_cpu_n) begin
            state_q      <= RUN;
            wait_cnt     <= '0;
            mem_err_q    <= 1'b0;
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.halt_req) begin
                        state_q <= HALT;
                    end else if (mem_stall) begin
                        state_q  <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.halt_req) begin
                        state_q <= HALT;
                    end else if (mem_stall) begin
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            state_q   <= HALT;
                            mem_err_q <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        state_q  <= RUN;
                        wait_cnt <= '0;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q  <= RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (stall_pc && (state_q != HALT) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (hz.have_inst_wb && (retire_cnt_q != '1))
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall_pc      = stall_pc;
    assign hz.stall_if_id   = stall_if_id;
    assign hz.stall_id_ex   = stall_id_ex;
    assign hz.stall_ex_mem  = stall_ex_mem;
    assign hz.flush_if_id   = flush_if_id;
    assign hz.flush_id_ex   = flush_id_ex;
    assign hz.bubble_mem_wb = bubble_mem_wb;
    assign hz.state         = state_q;
    assign hz.mem_err       = mem_err_q;
    assign hz.stall_cnt     = stall_cnt_q;
    assign hz.retire_cnt    = retire_cnt_q;

endmodule
